// File: rtl/fpu_req_arbiter_if.sv
// fpu_req_arbiter_if: requester-side request/response bundle for the FPU arbiter
interface fpu_req_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [3*NUM_REQ-1:0]  req_op;
  logic [2*NUM_REQ-1:0]  req_rmode;
  logic [32*NUM_REQ-1:0] req_opa;
  logic [32*NUM_REQ-1:0] req_opb;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [NUM_REQ-1:0]    resp_ready;
  logic [31:0]           resp_data;
  logic [7:0]            resp_flags;
  logic                  resp_err;
  modport master (
    output req_valid, req_op, req_rmode, req_opa, req_opb, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_flags, resp_err
  );
  modport slave (
    input  req_valid, req_op, req_rmode, req_opa, req_opb, resp_ready,
    output req_ready, resp_valid, resp_data, resp_flags, resp_err
  );
endinterface

// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: round-robin sharing of one single-issue FPU among NUM_REQ requesters
module fpu_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FPU_LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst,
  fpu_req_arbiter_if.slave   bus,
  output logic [2:0]         o_fpu_op,
  output logic [1:0]         o_fpu_rmode,
  output logic [31:0]        o_fpu_opa,
  output logic [31:0]        o_fpu_opb,
  input  logic [31:0]        i_fpu_out,
  input  logic [7:0]         i_fpu_flags,
  output logic               o_busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t          r_state, w_next;
  logic [IW-1:0]   r_ptr, r_owner, w_gidx;
  logic [IW:0]     w_sum, w_idx;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_resp_data;
  logic [7:0]      r_resp_flags;
  logic            r_resp_err;
  logic            w_found, w_hs, w_illegal, w_done;
  logic [NUM_REQ-1:0] w_one;
  assign w_one = {{(NUM_REQ-1){1'b0}}, 1'b1};
  // Scan downward so the lowest offset from r_ptr is the last (winning) assignment
  always_comb begin
    w_gidx = '0;
    w_sum  = '0;
    w_idx  = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      w_idx = (w_sum >= (IW+1)'(NUM_REQ)) ? w_sum - (IW+1)'(NUM_REQ) : w_sum;
      if (bus.req_valid[w_idx[IW-1:0]]) w_gidx = w_idx[IW-1:0];
    end
    w_found = |bus.req_valid;
  end
  assign w_hs      = (r_state == IDLE) && w_found;
  assign w_illegal = bus.req_op[3*w_gidx+2];
  assign w_done    = r_cnt == CW'(FPU_LATENCY-1);
  assign bus.req_ready  = (r_state == IDLE && !rst && w_found) ? w_one << w_gidx : '0;
  assign bus.resp_valid = (r_state == RESP) ? w_one << r_owner : '0;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_flags = r_resp_flags;
  assign bus.resp_err   = r_resp_err;
  assign o_busy         = r_state != IDLE;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_hs ? (w_illegal ? RESP : EXEC) : IDLE)
           : (r_state == EXEC) ? (w_done ? RESP : EXEC)
           : (bus.resp_ready[r_owner] ? IDLE : RESP);
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= '0;
      r_owner      <= '0;
      r_cnt        <= '0;
      r_resp_data  <= '0;
      r_resp_flags <= '0;
      r_resp_err   <= 1'b0;
      o_fpu_op     <= '0;
      o_fpu_rmode  <= '0;
      o_fpu_opa    <= '0;
      o_fpu_opb    <= '0;
    end else begin
      if (w_hs) begin
        r_owner <= w_gidx;
        r_ptr   <= (w_gidx == IW'(NUM_REQ-1)) ? '0 : w_gidx + 1'b1;
        r_cnt   <= '0;
        if (w_illegal) begin
          r_resp_data  <= '0;
          r_resp_flags <= '0;
          r_resp_err   <= 1'b1;
        end else begin
          o_fpu_op    <= bus.req_op[3*w_gidx +: 3];
          o_fpu_rmode <= bus.req_rmode[2*w_gidx +: 2];
          o_fpu_opa   <= bus.req_opa[32*w_gidx +: 32];
          o_fpu_opb   <= bus.req_opb[32*w_gidx +: 32];
        end
      end
      if (r_state == EXEC) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_done) begin
          r_resp_data  <= i_fpu_out;
          r_resp_flags <= i_fpu_flags;
          r_resp_err   <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_fpu_req_arbiter.sv
// tb_fpu_req_arbiter: directed checks of grant order, timing, illegal ops, backpressure and reset
module tb_fpu_req_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  fpu_req_arbiter_if #(.NUM_REQ(4)) bus();
  logic [2:0]  fpu_op;
  logic [1:0]  fpu_rmode;
  logic [31:0] fpu_opa, fpu_opb, fpu_out;
  logic [7:0]  fpu_flags;
  logic        busy;
  fpu_req_arbiter #(.NUM_REQ(4), .FPU_LATENCY(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .o_fpu_op(fpu_op), .o_fpu_rmode(fpu_rmode), .o_fpu_opa(fpu_opa), .o_fpu_opb(fpu_opb),
    .i_fpu_out(fpu_out), .i_fpu_flags(fpu_flags), .o_busy(busy)
  );
  int n_chk = 0, n_err = 0, cyc = 0, m_c = 0, n_acc = 0, n_rsp = 0;
  int acc_idx[32], acc_cyc[32];
  logic [31:0] rsp_data[32];
  logic [7:0]  rsp_flags[32];
  logic [68:0] m_prev = '0;
  logic        div0;
  // FPU model: result only becomes valid once inputs have been stable for latency-1 edges
  always @(negedge clk) begin
    if ({fpu_op, fpu_rmode, fpu_opa, fpu_opb} != m_prev) begin
      m_prev = {fpu_op, fpu_rmode, fpu_opa, fpu_opb};
      m_c = 0;
    end else m_c++;
  end
  assign div0      = fpu_op == 3'd3 && fpu_opb == 32'd0;
  assign fpu_out   = (m_c >= 3) ? (div0 ? 32'h7F80_0000 : fpu_opa + fpu_opb + {29'd0, fpu_op}) : 32'hDEAD_BEEF;
  assign fpu_flags = (m_c >= 3) ? (div0 ? 8'h81 : fpu_opb[7:0]) : 8'hEE;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        if (bus.req_valid[i] && bus.req_ready[i] && n_acc < 32) begin
          acc_idx[n_acc] = i;
          acc_cyc[n_acc] = cyc;
          n_acc++;
        end
      if (|(bus.resp_valid & bus.resp_ready) && n_rsp < 32) begin
        rsp_data[n_rsp]  = bus.resp_data;
        rsp_flags[n_rsp] = bus.resp_flags;
        n_rsp++;
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_acc(input int n);
    for (int g = 0; g < 60 && n_acc < n; g++) step();
    chk("acc_count", n_acc, n);
  endtask
  task automatic drain();
    for (int g = 0; g < 40 && busy; g++) step();
    chk("drain_busy", busy, 0);
  endtask
  task automatic set_req(input int i, input logic [2:0] op, input logic [1:0] rm, input logic [31:0] a, input logic [31:0] b);
    bus.req_op[3*i +: 3]     = op;
    bus.req_rmode[2*i +: 2]  = rm;
    bus.req_opa[32*i +: 32]  = a;
    bus.req_opb[32*i +: 32]  = b;
  endtask
  initial begin
    int ab, rb;
    logic [3:0] seen;
    logic [31:0] exp_d[4] = '{32'h11, 32'h23, 32'h35, 32'h47};
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.resp_ready = '0;
    bus.req_op = '0; bus.req_rmode = '0; bus.req_opa = '0; bus.req_opb = '0;
    step(); step();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_resp_flags", bus.resp_flags, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_fpu", {fpu_op, fpu_rmode, fpu_opa, fpu_opb}, 0);
    chk("rst_busy", busy, 0);
    bus.req_valid = '0;
    rst = 1'b0;
    // single legal divide by zero from requester 2
    set_req(2, 3'd3, 2'd1, 32'h3F80_0000, 32'd0);
    bus.req_valid = 4'b0100;
    #1 chk("t1_req_ready", bus.req_ready, 4'b0100);
    step();
    bus.req_valid = '0;
    chk("t1_busy", busy, 1);
    chk("t1_fpu_op", fpu_op, 3);
    chk("t1_fpu_rmode", fpu_rmode, 1);
    chk("t1_fpu_opa", fpu_opa, 32'h3F80_0000);
    chk("t1_fpu_opb", fpu_opb, 0);
    repeat (3) step();
    chk("t1_resp_early", bus.resp_valid, 0);
    step();
    chk("t1_resp_valid", bus.resp_valid, 4'b0100);
    chk("t1_resp_data", bus.resp_data, 32'h7F80_0000);
    chk("t1_resp_flags", bus.resp_flags, 8'h81);
    chk("t1_resp_err", bus.resp_err, 0);
    bus.resp_ready = 4'b0100;
    step();
    chk("t1_busy_done", busy, 0);
    chk("t1_resp_done", bus.resp_valid, 0);
    // round-robin fairness with all requesters valid and responses always accepted
    rst = 1'b1; step(); rst = 1'b0;
    set_req(0, 3'd0, 2'd0, 32'h10, 32'h01);
    set_req(1, 3'd1, 2'd0, 32'h20, 32'h02);
    set_req(2, 3'd2, 2'd0, 32'h30, 32'h03);
    set_req(3, 3'd3, 2'd0, 32'h40, 32'h04);
    ab = n_acc; rb = n_rsp;
    bus.resp_ready = 4'hF;
    bus.req_valid = 4'hF;
    wait_acc(ab + 5);
    bus.req_valid = '0;
    drain();
    for (int k = 0; k < 5; k++) chk($sformatf("rr_idx%0d", k), acc_idx[ab+k], k % 4);
    for (int k = 1; k < 5; k++) chk($sformatf("rr_gap%0d", k), acc_cyc[ab+k] - acc_cyc[ab+k-1], 6);
    for (int k = 0; k < 4; k++) chk($sformatf("rr_data%0d", k), rsp_data[rb+k], exp_d[k]);
    for (int k = 0; k < 4; k++) chk($sformatf("rr_flags%0d", k), rsp_flags[rb+k], k + 1);
    // move rr_ptr to 3, then only requesters 1 and 3 valid
    set_req(2, 3'd0, 2'd0, 32'h5, 32'h6);
    ab = n_acc;
    bus.req_valid = 4'b0100;
    wait_acc(ab + 1);
    bus.req_valid = '0;
    drain();
    chk("wrap_pre", acc_idx[ab], 2);
    ab = n_acc; rb = n_rsp;
    bus.req_valid = 4'b1010;
    wait_acc(ab + 2);
    bus.req_valid = '0;
    drain();
    chk("wrap_first", acc_idx[ab], 3);
    chk("wrap_second", acc_idx[ab+1], 1);
    chk("wrap_data3", rsp_data[rb], 32'h47);
    chk("wrap_data1", rsp_data[rb+1], 32'h23);
    bus.req_valid = 4'hF;
    #1 chk("wrap_ptr2", bus.req_ready, 4'b0100);
    bus.req_valid = '0;
    // illegal opcode from requester 0 bypasses the FPU
    bus.resp_ready = '0;
    set_req(0, 3'd5, 2'd0, 32'hAAAA, 32'hBBBB);
    bus.req_valid = 4'b0001;
    #1 chk("ill_req_ready", bus.req_ready, 4'b0001);
    step();
    bus.req_valid = '0;
    chk("ill_resp_valid", bus.resp_valid, 4'b0001);
    chk("ill_resp_err", bus.resp_err, 1);
    chk("ill_resp_data", bus.resp_data, 0);
    chk("ill_resp_flags", bus.resp_flags, 0);
    chk("ill_fpu_op", fpu_op, 1);
    chk("ill_fpu_opa", fpu_opa, 32'h20);
    chk("ill_fpu_opb", fpu_opb, 32'h02);
    bus.resp_ready = 4'b0001;
    step();
    chk("ill_busy_done", busy, 0);
    // response backpressure on requester 1, with overflow and underflow both flagged
    bus.resp_ready = '0;
    set_req(1, 3'd2, 2'd0, 32'h100, 32'h0C);
    bus.req_valid = 4'b0010;
    #1 chk("bp_req_ready", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = 4'b1001;
    repeat (4) step();
    for (int k = 0; k < 10; k++) begin
      bus.resp_ready = 4'b1101;
      chk("bp_resp_valid", bus.resp_valid, 4'b0010);
      chk("bp_resp_data", bus.resp_data, 32'h10E);
      chk("bp_resp_flags", bus.resp_flags, 8'h0C);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_busy", busy, 1);
      step();
    end
    bus.req_valid = '0;
    bus.resp_ready = 4'b0010;
    step();
    chk("bp_busy_done", busy, 0);
    bus.resp_ready = '0;
    // reset in the second EXEC cycle aborts the operation
    set_req(3, 3'd0, 2'd0, 32'h7, 32'h1);
    bus.req_valid = 4'b1000;
    #1 chk("rx_req_ready", bus.req_ready, 4'b1000);
    step();
    bus.req_valid = '0;
    step();
    rst = 1'b1;
    bus.req_valid = 4'b0001;
    #1 chk("rx_ready_in_rst", bus.req_ready, 0);
    step();
    chk("rx_fpu", {fpu_op, fpu_rmode, fpu_opa, fpu_opb}, 0);
    chk("rx_resp_valid", bus.resp_valid, 0);
    chk("rx_resp_data", bus.resp_data, 0);
    chk("rx_resp_flags", bus.resp_flags, 0);
    chk("rx_resp_err", bus.resp_err, 0);
    chk("rx_busy", busy, 0);
    rst = 1'b0;
    bus.req_valid = '0;
    bus.resp_ready = 4'hF;
    seen = '0;
    repeat (6) begin
      step();
      seen |= bus.resp_valid;
    end
    chk("rx_no_resp", seen, 0);
    set_req(1, 3'd0, 2'd0, 32'h20, 32'h02);
    rb = n_rsp;
    bus.req_valid = 4'b1010;
    #1 chk("rx_grant_ptr0", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = '0;
    drain();
    chk("rx_rsp_count", n_rsp, rb + 1);
    chk("rx_rsp_data", rsp_data[rb], 32'h22);
    chk("rx_rsp_flags", rsp_flags[rb], 8'h02);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fpu_req_arbiter.md
# fpu_req_arbiter

Round-robin arbiter and sequencer that shares the single-issue FPU datapath (`fpu_op`, `rmode`, `opa`, `opb` in; `out` and exception flags back) among `NUM_REQ` requesters. The block accepts one operation at a time over a valid/ready handshake and drives the FPU operands stable for the full FPU latency. It captures the result and flags, then returns them to the originating requester over a second valid/ready handshake. It sits between the requester ports and the FPU instance in `top`.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `FPU_LATENCY`, 4, cycles from FPU inputs stable to `fpu_out`/flags valid (≥1)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  NUM_REQ  per-requester operation valid
- `req_ready`  out  NUM_REQ  per-requester accept (one-hot or zero)
- `req_op`  in  3*NUM_REQ  fpu_op per requester (0 add, 1 sub, 2 mul, 3 div; 4–7 illegal)
- `req_rmode`  in  2*NUM_REQ  rounding mode per requester
- `req_opa`, `req_opb`  in  32*NUM_REQ  operands per requester (requester i at bits [32i+31:32i])
- `resp_valid`  out  NUM_REQ  response valid to the owning requester
- `resp_ready`  in  NUM_REQ  response accept
- `resp_data`  out  32  captured FPU result
- `resp_flags`  out  8  {inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero}, MSB first
- `resp_err`  out  1  illegal opcode, no FPU use
- `fpu_op`  out  3, `fpu_rmode` out 2, `fpu_opa` out 32, `fpu_opb` out 32: drive the FPU
- `fpu_out`  in  32, `fpu_flags` in 8 (same order as `resp_flags`): FPU results
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM: IDLE → EXEC → RESP → IDLE. Illegal opcodes take IDLE → RESP directly.
- IDLE:
  - Grant goes to the first asserted `req_valid` searching from `rr_ptr` upward, wrapping past NUM_REQ-1 to 0.
  - `req_ready[g]` is combinational: it equals (state==IDLE) & grant[g]. Only one bit is ever high.
  - Handshake occurs when `req_valid[g]` & `req_ready[g]`. On it, latch g as `owner` and set `rr_ptr` = (g+1) mod NUM_REQ.
  - Legal op: register op, rmode, opa and opb onto the `fpu_*` outputs, clear the cycle counter, go to EXEC.
  - Illegal op (4–7): `fpu_*` outputs are unchanged. Set `resp_data`=0, `resp_flags`=0, `resp_err`=1, go to RESP.
- EXEC:
  - `fpu_*` outputs are held constant and the counter increments each cycle.
  - In the cycle the counter equals FPU_LATENCY-1, sample `fpu_out`→`resp_data` and `fpu_flags`→`resp_flags`, set `resp_err`=0, go to RESP.
- RESP:
  - `resp_valid[owner]`=1. All other `resp_valid` bits are 0.
  - `resp_data`, `resp_flags` and `resp_err` are stable until `resp_ready[owner]`=1, then go to IDLE.
  - `resp_ready` bits of non-owners are ignored.
- Requesters must hold `req_valid` and payload until the handshake. A dropped `req_valid` before the handshake is legal and withdraws the request.
- The FPU is never driven with a new operation while EXEC or RESP is active. There is one outstanding operation maximum.
- `resp_flags` passes FPU flags through unmodified. `overflow`&`underflow` both set is forwarded as-is; the arbiter does not filter it.

## Timing
- Reset (synchronous, `rst`=1 at a clock edge):
  - state=IDLE, `rr_ptr`=0, counter=0.
  - Outputs: `req_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_flags`=0, `resp_err`=0, `fpu_op`=0, `fpu_rmode`=0, `fpu_opa`=0, `fpu_opb`=0, `busy`=0.
  - `req_ready` is forced to 0 while `rst`=1.
- Reset during EXEC or RESP aborts the operation. No response is produced, and the next edge after `rst` falls is IDLE.
- Legal op accepted at edge T: `fpu_*` valid from T+1; result sampled at edge T+FPU_LATENCY; `resp_valid` high from T+FPU_LATENCY+1.
- Illegal op accepted at T: `resp_valid` high from T+1.
- Response accepted at edge R: state is IDLE in cycle R+1. A new grant and handshake are possible at R+1, so the minimum issue interval is FPU_LATENCY+2 cycles.
- `resp_ready` high already when `resp_valid` rises: the response completes on that first RESP edge.
- `busy` goes high the cycle after acceptance and low the cycle after response acceptance.

## Test plan
- Single legal op: NUM_REQ=4, FPU_LATENCY=4. Req 2 sends op=3, opa=0x3F800000, opb=0. Model returns out=0x7F800000 with inf and div_by_zero set. Required: `req_ready[2]` at T; `resp_valid[2]` at T+5; `resp_flags`=0x81; `resp_err`=0.
- Round-robin fairness: all four `req_valid` held high with `resp_ready` tied high. Required grant order 0,1,2,3,0; each accept is FPU_LATENCY+2=6 cycles after the previous one.
- Wrap and skip: `rr_ptr`=3, only requesters 1 and 3 valid → grant 3 then 1. Afterwards `rr_ptr`=2.
- Illegal op: req 0 sends op=5. Required: `resp_valid[0]` at T+1; `resp_err`=1; `resp_data`=0; `fpu_*` unchanged.
- Response backpressure: `resp_ready[1]` held low 10 cycles. Required: `resp_*` stable, no new `req_ready`, `busy`=1 throughout.
- Reset mid-EXEC: assert `rst` at the 2nd EXEC cycle. Required: all outputs 0 next edge, no `resp_valid`; a fresh request after reset completes normally with `rr_ptr` restarting at 0.
